// File: rtl/run_sequencer_pkg.sv
// Shared definitions for the run-control sequencer: FSM state encoding and
// the default width of the performance counters.
package definitions;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    LDWAIT,
    DONE
  } seq_state_t;

  localparam int kSEQ_CYC_W = 16;

endpackage

// File: rtl/run_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear. It holds at all-ones instead
// of wrapping, so a long program still reports the largest representable count.
module sat_counter
  import definitions::*;
#(
  parameter int W = kSEQ_CYC_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

  // Clear has priority over increment; the increment stops at the maximum value.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != MAX_VAL)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Run-control sequencer for the single-cycle core. It starts the program on a
// harness pulse, gates PC advance and register/memory writes, holds the core
// while a load waits on data memory, stops on halt, and counts cycles and
// retired instructions.
module run_sequencer
  import definitions::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CYC_W   = kSEQ_CYC_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             ReadMem,
  input  logic             WriteMem,
  output logic             pc_init,
  output logic             pc_en,
  output logic             reg_we_gate,
  output logic             mem_we_gate,
  output logic             stall,
  output logic             done,
  output logic [CYC_W-1:0] cycle_ct,
  output logic [CYC_W-1:0] instr_ct
);

  // A zero-latency memory still needs a one-bit counter so the declaration stays legal.
  localparam int WAIT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = (MEM_LAT > 0) ? WAIT_W'(MEM_LAT - 1) : '0;

  seq_state_t        state;
  logic [WAIT_W-1:0] wait_ct;
  logic              load_stall;
  logic              cnt_clr;
  logic              cyc_inc;
  logic              instr_inc;

  assign load_stall = ReadMem && (MEM_LAT > 0);

  // State register and load wait counter; reset parks the sequencer in IDLE with no pending wait.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      wait_ct <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= INIT;
        end
        INIT: begin
          state <= RUN;
        end
        RUN: begin
          if (halt_req) begin
            state <= DONE;
          end else if (load_stall) begin
            state   <= LDWAIT;
            wait_ct <= WAIT_LOAD;
          end
        end
        LDWAIT: begin
          if (wait_ct != '0) begin
            wait_ct <= wait_ct - WAIT_W'(1);
          end else begin
            state <= RUN;
          end
        end
        DONE: begin
          if (start) state <= INIT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Gate and status outputs follow the state and, in RUN, the decoder flags of the current instruction.
  always_comb begin
    pc_init     = 1'b0;
    pc_en       = 1'b0;
    reg_we_gate = 1'b0;
    mem_we_gate = 1'b0;
    stall       = 1'b0;
    done        = 1'b0;
    cnt_clr     = 1'b0;
    cyc_inc     = 1'b0;
    instr_inc   = 1'b0;
    case (state)
      INIT: begin
        pc_init = 1'b1;
        cnt_clr = 1'b1;
      end
      RUN: begin
        cyc_inc = 1'b1;
        if (halt_req) begin
          instr_inc = 1'b1;
        end else if (load_stall) begin
          stall = 1'b1;
        end else begin
          pc_en       = 1'b1;
          reg_we_gate = 1'b1;
          mem_we_gate = WriteMem;
          instr_inc   = 1'b1;
        end
      end
      LDWAIT: begin
        stall   = 1'b1;
        cyc_inc = 1'b1;
        if (wait_ct == '0) begin
          pc_en       = 1'b1;
          reg_we_gate = 1'b1;
          instr_inc   = 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        pc_init = 1'b0;
      end
    endcase
  end

  sat_counter #(.W(CYC_W)) u_cycle_ct (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (cnt_clr),
    .inc   (cyc_inc),
    .q     (cycle_ct)
  );

  sat_counter #(.W(CYC_W)) u_instr_ct (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (cnt_clr),
    .inc   (instr_inc),
    .q     (instr_ct)
  );

endmodule
